// File: rtl/sweep_ctrl.sv
// sweep_ctrl: frequency-sweep sequencer feeding a DDS compiler config port.
// A button press starts a sweep of phase-increment words from START_FREQ to
// STOP_FREQ in STEP increments. Each word is offered on an AXI-Stream config
// channel and held for DWELL clocks once accepted. MOD selects a single
// up-sweep ("linear") or an up-then-down sweep ("triangle").
//
// Ports
//   clk           in   1   system clock
//   rst           in   1   synchronous active-high reset
//   i_btn_start   in   1   asynchronous button level
//   o_cfg_tdata   out  32  phase-increment word
//   o_cfg_tvalid  out  1   AXI-S valid
//   i_cfg_tready  in   1   AXI-S ready
//   o_busy        out  1   sweep in progress
//   o_done        out  1   one-clock pulse after the final word is accepted
//   o_freq        out  32  last accepted word
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a start press
// SEND  | word offered on the config channel, held until accepted
// DWELL | holding the accepted word, down-counting the dwell timer
// DONE  | one-clock completion pulse

module sweep_ctrl #(
    parameter logic [31:0] START_FREQ = 32'h0000_1000,
    parameter logic [31:0] STOP_FREQ  = 32'h0000_FFFF,
    parameter logic [31:0] STEP       = 32'h0000_0100,
    parameter int unsigned DWELL      = 1000,
    parameter string       MOD        = "linear"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_btn_start,
    output logic [31:0] o_cfg_tdata,
    output logic        o_cfg_tvalid,
    input  logic        i_cfg_tready,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_freq
);

    localparam bit          IS_TRI   = (MOD == "triangle");
    localparam logic [31:0] DWELL_M1 = 32'(DWELL - 1);

    if (!(MOD == "linear" || MOD == "triangle")) begin : g_bad_mod
        $error("sweep_ctrl: MOD must be \"linear\" or \"triangle\"");
    end
    if (START_FREQ > STOP_FREQ) begin : g_bad_range
        $error("sweep_ctrl: START_FREQ must not exceed STOP_FREQ");
    end
    if (STEP == 32'd0) begin : g_bad_step
        $error("sweep_ctrl: STEP must be non-zero");
    end
    if (DWELL < 1) begin : g_bad_dwell
        $error("sweep_ctrl: DWELL must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_DWELL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cur_q, cur_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] freq_q, freq_d;
    logic        dir_down_q, dir_down_d;
    logic        abort_q, abort_d;

    logic        sync1_q, sync2_q, sync2_dly_q;
    logic        start_q;

    logic [31:0] up_next;
    logic [31:0] dn_next;
    logic        is_final;
    logic        is_turn;
    logic        tvalid;
    logic        done;

    // Two-flop synchronizer plus a registered rising-edge pulse; the extra
    // register keeps the press-to-valid latency at three clocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync2_dly_q <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            sync1_q     <= i_btn_start;
            sync2_q     <= sync1_q;
            sync2_dly_q <= sync2_q;
            start_q     <= sync2_q & ~sync2_dly_q;
        end
    end

    // Distances are compared before stepping so the sum/difference never wraps.
    assign up_next  = (STOP_FREQ - cur_q <= STEP) ? STOP_FREQ : cur_q + STEP;
    assign dn_next  = (cur_q - START_FREQ <= STEP) ? START_FREQ : cur_q - STEP;

    // Triangle only finishes on START reached on the way down, so a
    // degenerate START==STOP triangle emits its word twice.
    assign is_final = IS_TRI ? (dir_down_q && (cur_q == START_FREQ))
                             : (cur_q == STOP_FREQ);
    assign is_turn  = IS_TRI && !dir_down_q && (cur_q == STOP_FREQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cur_q      <= 32'd0;
            cnt_q      <= 32'd0;
            freq_q     <= 32'd0;
            dir_down_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            cnt_q      <= cnt_d;
            freq_q     <= freq_d;
            dir_down_q <= dir_down_d;
            abort_q    <= abort_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        cnt_d      = cnt_q;
        freq_d     = freq_q;
        dir_down_d = dir_down_q;
        abort_d    = abort_q;
        tvalid     = 1'b0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (start_q) begin
                    cur_d      = START_FREQ;
                    dir_down_d = 1'b0;
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                tvalid = 1'b1;
                if (start_q) begin
                    abort_d = 1'b1;
                end
                // An abort never cuts a pending handshake short.
                if (i_cfg_tready) begin
                    freq_d = cur_q;
                    if (abort_q || start_q) begin
                        state_d = S_IDLE;
                    end else if (is_final) begin
                        state_d = S_DONE;
                    end else begin
                        if (is_turn) begin
                            dir_down_d = 1'b1;
                        end
                        cnt_d   = DWELL_M1;
                        state_d = S_DWELL;
                    end
                end
            end
            S_DWELL: begin
                if (abort_q || start_q) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 32'd0) begin
                    cur_d   = dir_down_q ? dn_next : up_next;
                    state_d = S_SEND;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_cfg_tdata  = cur_q;
    assign o_cfg_tvalid = tvalid;
    assign o_busy       = (state_q != S_IDLE);
    assign o_done       = done;
    assign o_freq       = freq_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Bench for sweep_ctrl: four instances with different sweep shapes share the
// clock, reset, button and ready. A behavioural model per instance, built on a
// precomputed word list, is checked against every instance on every cycle.

module tb_sweep_ctrl;

    localparam int NI = 4;
    localparam int PH_IDLE = 0;
    localparam int PH_SEND = 1;
    localparam int PH_DWELL = 2;
    localparam int PH_DONE = 3;

    logic clk = 1'b0;
    logic rst;
    logic btn;
    logic tready;

    logic [31:0] tdata [NI];
    logic        tvalid[NI];
    logic        busy  [NI];
    logic        done  [NI];
    logic [31:0] freq  [NI];

    always #5 clk = ~clk;

    sweep_ctrl #(.START_FREQ(32'd1000), .STOP_FREQ(32'd1450), .STEP(32'd100),
                 .DWELL(4), .MOD("linear")) u_lin (
        .clk(clk), .rst(rst), .i_btn_start(btn),
        .o_cfg_tdata(tdata[0]), .o_cfg_tvalid(tvalid[0]), .i_cfg_tready(tready),
        .o_busy(busy[0]), .o_done(done[0]), .o_freq(freq[0]));

    sweep_ctrl #(.START_FREQ(32'd1000), .STOP_FREQ(32'd1400), .STEP(32'd100),
                 .DWELL(4), .MOD("triangle")) u_tri (
        .clk(clk), .rst(rst), .i_btn_start(btn),
        .o_cfg_tdata(tdata[1]), .o_cfg_tvalid(tvalid[1]), .i_cfg_tready(tready),
        .o_busy(busy[1]), .o_done(done[1]), .o_freq(freq[1]));

    sweep_ctrl #(.START_FREQ(32'hFFFF_FE00), .STOP_FREQ(32'hFFFF_FFFF), .STEP(32'h180),
                 .DWELL(3), .MOD("linear")) u_ovf (
        .clk(clk), .rst(rst), .i_btn_start(btn),
        .o_cfg_tdata(tdata[2]), .o_cfg_tvalid(tvalid[2]), .i_cfg_tready(tready),
        .o_busy(busy[2]), .o_done(done[2]), .o_freq(freq[2]));

    sweep_ctrl #(.START_FREQ(32'd500), .STOP_FREQ(32'd500), .STEP(32'd7),
                 .DWELL(2), .MOD("triangle")) u_one (
        .clk(clk), .rst(rst), .i_btn_start(btn),
        .o_cfg_tdata(tdata[3]), .o_cfg_tvalid(tvalid[3]), .i_cfg_tready(tready),
        .o_busy(busy[3]), .o_done(done[3]), .o_freq(freq[3]));

    // model configuration and state
    logic [31:0] m_start[NI], m_stop[NI], m_step[NI];
    int          m_dwell[NI];
    bit          m_tri  [NI];
    logic [31:0] seq    [NI][16];
    int          seq_len[NI];

    int          ph  [NI];
    int          idx [NI];
    int          rem [NI];
    bit          abrt[NI];
    logic [31:0] mfreq[NI];
    logic [3:0]  hist;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d at %0t: got %h expected %h", nm, k, $time, act, exp);
        end
    endtask

    task automatic push(input int k, input longint w);
        seq[k][seq_len[k]] = w[31:0];
        seq_len[k] = seq_len[k] + 1;
    endtask

    // Word list of a complete sweep, straight from the stepping rules.
    task automatic build(input int k);
        longint w, lo, hi, st;
        lo = longint'(m_start[k]);
        hi = longint'(m_stop[k]);
        st = longint'(m_step[k]);
        seq_len[k] = 0;
        w = lo;
        push(k, w);
        while (w != hi) begin
            w = w + st;
            if (w > hi) w = hi;
            push(k, w);
        end
        if (m_tri[k]) begin
            if (lo == hi) begin
                push(k, lo);
            end else begin
                while (w != lo) begin
                    w = w - st;
                    if (w < lo) w = lo;
                    push(k, w);
                end
            end
        end
    endtask

    // Cycle model: start events arrive three edges after the button is sampled high.
    initial begin
        hist = 4'b0;
        for (int k = 0; k < NI; k++) begin
            ph[k] = PH_IDLE; idx[k] = 0; rem[k] = 0; abrt[k] = 1'b0; mfreq[k] = 32'd0;
        end
        forever begin
            @(posedge clk);
            if (rst) begin
                hist = 4'b0;
                for (int k = 0; k < NI; k++) begin
                    ph[k] = PH_IDLE; abrt[k] = 1'b0; mfreq[k] = 32'd0;
                end
            end else begin
                bit evt;
                evt = hist[2] & ~hist[3];
                hist = {hist[2:0], btn};
                for (int k = 0; k < NI; k++) begin
                    case (ph[k])
                        PH_IDLE: if (evt) begin
                            ph[k] = PH_SEND; idx[k] = 0; abrt[k] = 1'b0;
                        end
                        PH_SEND: begin
                            if (evt) abrt[k] = 1'b1;
                            if (tready) begin
                                mfreq[k] = seq[k][idx[k]];
                                if (abrt[k]) ph[k] = PH_IDLE;
                                else if (idx[k] == seq_len[k] - 1) ph[k] = PH_DONE;
                                else begin ph[k] = PH_DWELL; rem[k] = m_dwell[k]; end
                            end
                        end
                        PH_DWELL: begin
                            if (evt || abrt[k]) ph[k] = PH_IDLE;
                            else begin
                                rem[k] = rem[k] - 1;
                                if (rem[k] == 0) begin ph[k] = PH_SEND; idx[k] = idx[k] + 1; end
                            end
                        end
                        default: begin ph[k] = PH_IDLE; abrt[k] = 1'b0; end
                    endcase
                end
            end
        end
    end

    // Per-cycle comparison of every instance against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int k = 0; k < NI; k++) begin
                    chk("tvalid", k, 32'(tvalid[k]), 32'(ph[k] == PH_SEND));
                    chk("busy",   k, 32'(busy[k]),   32'(ph[k] != PH_IDLE));
                    chk("done",   k, 32'(done[k]),   32'(ph[k] == PH_DONE));
                    chk("freq",   k, freq[k],        mfreq[k]);
                    if (ph[k] == PH_SEND) chk("tdata", k, tdata[k], seq[k][idx[k]]);
                end
            end
        end
    end

    initial begin
        int n_acc, n_done_tri, n_done_lin, n_done;
        bit found;

        m_start = '{32'd1000, 32'd1000, 32'hFFFF_FE00, 32'd500};
        m_stop  = '{32'd1450, 32'd1400, 32'hFFFF_FFFF, 32'd500};
        m_step  = '{32'd100,  32'd100,  32'h180,       32'd7};
        m_dwell = '{4, 4, 3, 2};
        m_tri   = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < NI; k++) build(k);

        // pin the model's word lists
        chk("len_lin", 0, 32'(seq_len[0]), 32'd6);
        chk("lin_last", 0, seq[0][5], 32'd1450);
        chk("len_tri", 1, 32'(seq_len[1]), 32'd9);
        chk("tri_turn", 1, seq[1][4], 32'd1400);
        chk("tri_down", 1, seq[1][5], 32'd1300);
        chk("tri_last", 1, seq[1][8], 32'd1000);
        chk("len_ovf", 2, 32'(seq_len[2]), 32'd3);
        chk("ovf_mid", 2, seq[2][1], 32'hFFFF_FF80);
        chk("ovf_last", 2, seq[2][2], 32'hFFFF_FFFF);
        chk("len_one", 3, 32'(seq_len[3]), 32'd2);

        rst = 1'b1; btn = 1'b0; tready = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_tdata", k, tdata[k], 32'd0);
            chk("rst_tvalid", k, 32'(tvalid[k]), 32'd0);
            chk("rst_busy", k, 32'(busy[k]), 32'd0);
            chk("rst_done", k, 32'(done[k]), 32'd0);
            chk("rst_freq", k, freq[k], 32'd0);
        end
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // press latency: valid rises after the third edge following the sample
        btn = 1'b1;
        repeat (3) @(negedge clk);
        chk("lat_early", 0, 32'(tvalid[0]), 32'd0);
        @(negedge clk);
        chk("lat_valid", 0, 32'(tvalid[0]), 32'd1);
        chk("lat_word", 0, tdata[0], 32'd1000);

        n_acc = 0; n_done_tri = 0; n_done_lin = 0;
        for (int i = 0; i < 150; i++) begin
            if (tvalid[1]) n_acc++;
            if (done[1]) n_done_tri++;
            if (done[0]) n_done_lin++;
            @(negedge clk);
        end
        btn = 1'b0;
        chk("tri_words", 1, 32'(n_acc), 32'd9);
        chk("tri_dones", 1, 32'(n_done_tri), 32'd1);
        chk("lin_dones", 0, 32'(n_done_lin), 32'd1);
        chk("tri_freq", 1, freq[1], 32'd1000);
        chk("tri_idle", 1, 32'(busy[1]), 32'd0);
        chk("lin_freq", 0, freq[0], 32'd1450);
        chk("ovf_freq", 2, freq[2], 32'hFFFF_FFFF);
        chk("one_freq", 3, freq[3], 32'd500);

        // abort while dwelling on 1200
        repeat (3) @(negedge clk);
        btn = 1'b1;
        repeat (3) @(negedge clk);
        btn = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (freq[0] == 32'd1200 && !tvalid[0] && busy[0]) found = 1'b1;
        end
        chk("abort_reach", 0, 32'(found), 32'd1);
        btn = 1'b1;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done[0]) n_done++;
        end
        btn = 1'b0;
        chk("abort_nodone", 0, 32'(n_done), 32'd0);
        chk("abort_idle", 0, 32'(busy[0]), 32'd0);
        chk("abort_freq", 0, freq[0], 32'd1200);
        repeat (60) @(negedge clk);

        // randomized presses, back-pressure and resets
        for (int i = 0; i < 6000; i++) begin
            tready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) btn = ~btn;
            rst = ($urandom_range(0, 599) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        tready = 1'b1;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
